// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: single-cycle multiply, 32-step restoring
// divide, and ownership of the architectural HI/LO register pair.
//
// state | meaning
// IDLE  | ready for a new operation; mthi/mtlo complete here
// MUL   | product computed this cycle, written to HI/LO at the edge
// DIV   | one restoring-divide step per cycle
// FIX   | sign fixup of quotient/remainder, written to HI/LO at the edge
module mdu_ctrl #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        op_ready,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mul_signed;
   logic        q_neg;
   logic        r_neg;
   logic [63:0] rem_quo;

   logic        div_signed;
   logic [31:0] abs1;
   logic [31:0] abs2;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic [32:0] rem_top;
   logic        rem_ge;
   logic [31:0] rem_sub;
   logic [63:0] rem_quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign op_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   assign div_signed = (op_code == 3'd2);
   assign abs1 = (div_signed && src1[31]) ? -src1 : src1;
   assign abs2 = (div_signed && src2[31]) ? -src2 : src2;

   // 33x33 signed multiply, evaluated in 64 bits since only the low 64 bits matter
   assign mul_a   = {{32{mul_signed & op_a[31]}}, op_a};
   assign mul_b   = {{32{mul_signed & op_b[31]}}, op_b};
   assign product = mul_a * mul_b;

   // The shifted-out remainder bit makes the compare 33 bits wide
   assign rem_top      = rem_quo[63:31];
   assign rem_ge       = (rem_top >= {1'b0, op_b});
   assign rem_sub      = rem_top[31:0] - op_b;
   assign rem_quo_next = rem_ge ? {rem_sub, rem_quo[30:0], 1'b1}
                                : {rem_quo[62:0], 1'b0};

   assign quo_fix = q_neg ? -rem_quo[31:0]  : rem_quo[31:0];
   assign rem_fix = r_neg ? -rem_quo[63:32] : rem_quo[63:32];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         mul_signed <= 1'b0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         rem_quo    <= '0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid && !flush) begin
                  case (op_code)
                     3'd0, 3'd1: begin
                        op_a       <= src1;
                        op_b       <= src2;
                        mul_signed <= (op_code == 3'd0);
                        state      <= MUL;
                     end
                     3'd2, 3'd3: begin
                        op_b    <= abs2;
                        rem_quo <= {32'd0, abs1};
                        // Divide by zero leaves an all-ones quotient unfixed
                        q_neg   <= div_signed && (src1[31] ^ src2[31]) && (src2 != 32'd0);
                        r_neg   <= div_signed && src1[31];
                        cnt     <= '0;
                        state   <= DIV;
                     end
                     3'd4: hi <= src1;
                     3'd5: lo <= src1;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (!flush) begin
                  hi <= product[63:32];
                  lo <= product[31:0];
               end
               state <= IDLE;
            end
            DIV: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  rem_quo <= rem_quo_next;
                  cnt     <= cnt + 6'd1;
                  if (cnt == 6'(DIV_ITERS - 1))
                     state <= FIX;
               end
            end
            FIX: begin
               if (!flush) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiply, divide corner cases, mthi/mtlo,
// flush, held requests and asynchronous reset.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        flush = 1'b0;
   logic        op_ready;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_pass   = 0;
   int cycles;

   mdu_ctrl #(.DIV_ITERS(32)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .op_valid (op_valid),
      .op_code  (op_code),
      .src1     (src1),
      .src2     (src2),
      .flush    (flush),
      .op_ready (op_ready),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation for a single accept edge, then drop op_valid
   task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op_code  = code;
      src1     = a;
      src2     = b;
      tick();
      op_valid = 1'b0;
   endtask

   // Counts busy cycles, starting in the cycle after accept; bounded
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #12;
      check("reset_ready", 32'(op_ready), 32'd1);
      check("reset_busy",  32'(busy),     32'd0);
      check("reset_hi",    hi,            32'd0);
      check("reset_lo",    lo,            32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      tick();

      // mthi then mtlo back-to-back
      op_valid = 1'b1; op_code = 3'd4; src1 = 32'h11;
      tick();
      check("mthi_hi",   hi,         32'h11);
      check("mthi_busy", 32'(busy),  32'd0);
      op_code = 3'd5; src1 = 32'h22;
      tick();
      op_valid = 1'b0;
      check("mtlo_lo", lo, 32'h22);
      check("mtlo_hi", hi, 32'h11);

      // mult -3 * 5
      issue(3'd0, 32'hFFFF_FFFD, 32'd5);
      check("mult_busy_n1",  32'(busy),     32'd1);
      check("mult_ready_n1", 32'(op_ready), 32'd0);
      tick();
      check("mult_ready_n2", 32'(op_ready), 32'd1);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);

      // multu max * max
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // div -7/2 with a mult held on op_valid behind it
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      op_valid = 1'b1; op_code = 3'd0; src1 = 32'd3; src2 = 32'd4;
      wait_idle(cycles);
      check("div_busy_cycles", 32'(cycles), 32'd33);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_ready", 32'(op_ready), 32'd1);
      tick();
      op_valid = 1'b0;
      check("held_mult_busy", 32'(busy), 32'd1);
      tick();
      check("held_mult_lo", lo, 32'd12);
      check("held_mult_hi", hi, 32'd0);

      // divu by zero
      issue(3'd3, 32'h1234_5678, 32'd0);
      wait_idle(cycles);
      check("divu0_cycles", 32'(cycles), 32'd33);
      check("divu0_lo", lo, 32'hFFFF_FFFF);
      check("divu0_hi", hi, 32'h1234_5678);

      // signed div of a negative value by zero: no sign fixup
      issue(3'd2, 32'hFFFF_FFF9, 32'd0);
      wait_idle(cycles);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_hi", hi, 32'hFFFF_FFF9);

      // overflow case
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cycles);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);

      // divu 100/7
      issue(3'd3, 32'd100, 32'd7);
      wait_idle(cycles);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      // flush on iteration 10 of div 100/7
      issue(3'd4, 32'hA, 32'd0);
      issue(3'd5, 32'hB, 32'd0);
      issue(3'd2, 32'd100, 32'd7);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ready", 32'(op_ready), 32'd1);
      check("flush_busy",  32'(busy),     32'd0);
      check("flush_hi", hi, 32'hA);
      check("flush_lo", lo, 32'hB);
      repeat (30) tick();
      check("flush_hi_late", hi, 32'hA);
      check("flush_lo_late", lo, 32'hB);

      // flush in IDLE blocks mthi
      flush = 1'b1;
      issue(3'd4, 32'h55, 32'd0);
      flush = 1'b0;
      check("idle_flush_hi", hi, 32'hA);

      // async reset at iteration 15
      issue(3'd2, 32'd100, 32'd7);
      repeat (15) tick();
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      check("arst_ready", 32'(op_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
